// File: rtl/xgmii_rx_fifo_writer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xgmii_rx_fifo_writer_if : XGMII RX word in, FIFO write port out.
// Rev 1.0
// ----------------------------------------------------------------------------
interface xgmii_rx_fifo_writer_if;
  logic [71:0] xgmii_rxd;
  logic [71:0] din;
  logic        full;
  logic        wr_en;
  logic        wr_clk;

  modport master (input xgmii_rxd, input full, output din, output wr_en, output wr_clk);
  modport slave  (output xgmii_rxd, output full, input din, input wr_en, input wr_clk);
endinterface
`default_nettype wire

// File: rtl/xgmii_rx_fifo_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xgmii_rx_fifo_writer : packs XGMII RX words into a 72-bit FIFO with lane-4
// realignment, inter-frame idle gap and drop on full. Optional XGMII_STATS_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module xgmii_rx_fifo_writer #(
  parameter logic [3:0] GAP         = 4'h2,
  parameter bit         ALIGN_LANE4 = 1'b1,
  parameter int         CNT_W       = 32
) (
  input  wire logic              xgmii_rx_clk,
  input  wire logic              sys_rst_n,
  xgmii_rx_fifo_writer_if.master bus
`ifdef XGMII_STATS_EN
  ,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [CNT_W-1:0]       drop_cnt
`endif
);

  localparam logic [71:0] IDLE_WORD = 72'hff_0707070707070707;
  localparam logic [71:0] ERR_WORD  = 72'hff_07070707070707fe;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    FRAME     = 2'd2,
    DROP      = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  hold_ctrl, hold_ctrl_nxt;
  logic [31:0] hold_data, hold_data_nxt;
  logic        shift, shift_nxt;
  logic [3:0]  gap_cnt, gap_nxt;
  logic        err_pend, err_nxt;
  logic [71:0] din_q, din_nxt;
  logic        wr_en_q, wr_en_nxt;
  logic        do_idle;
`ifdef XGMII_STATS_EN
  logic        frame_inc, drop_inc;
`endif

  logic [7:0]  rx_ctrl;
  logic [63:0] rx_data;
  logic        is_idle, is_sof_l4;
  logic [71:0] merged, flush;

  assign rx_ctrl   = bus.xgmii_rxd[71:64];
  assign rx_data   = bus.xgmii_rxd[63:0];
  assign is_idle   = (rx_ctrl == 8'hff) && (rx_data[7:0] == 8'h07);
  assign is_sof_l4 = ALIGN_LANE4 && rx_ctrl[4] && (rx_data[39:32] == 8'hfb);
  // Held upper half of the previous word becomes lanes 0..3 of the output.
  assign merged    = {rx_ctrl[3:0], hold_ctrl, rx_data[31:0], hold_data};
  assign flush     = {4'hf, hold_ctrl, 32'h07070707, hold_data};

  always_comb begin
    state_nxt     = state;
    hold_ctrl_nxt = hold_ctrl;
    hold_data_nxt = hold_data;
    shift_nxt     = shift;
    gap_nxt       = gap_cnt;
    err_nxt       = err_pend;
    din_nxt       = din_q;
    wr_en_nxt     = 1'b0;
    do_idle       = 1'b0;
`ifdef XGMII_STATS_EN
    frame_inc     = 1'b0;
    drop_inc      = 1'b0;
`endif
    case (state)
      WAIT_IDLE: begin
        if (is_idle) state_nxt = IDLE;
      end
      IDLE: begin
        if (is_idle) begin
          do_idle = 1'b1;
        end else begin
          gap_nxt = GAP;
          if (bus.full) begin
            state_nxt = DROP;
            shift_nxt = 1'b0;
`ifdef XGMII_STATS_EN
            drop_inc  = 1'b1;
`endif
          end else if (is_sof_l4) begin
            if (shift) begin
              wr_en_nxt = 1'b1;
              din_nxt   = merged;
            end
            hold_ctrl_nxt = rx_ctrl[7:4];
            hold_data_nxt = rx_data[63:32];
            shift_nxt     = 1'b1;
            state_nxt     = FRAME;
          end else begin
            wr_en_nxt = 1'b1;
            din_nxt   = bus.xgmii_rxd;
            shift_nxt = 1'b0;
            state_nxt = FRAME;
          end
        end
      end
      FRAME: begin
        if (is_idle) begin
          state_nxt = IDLE;
          do_idle   = 1'b1;
`ifdef XGMII_STATS_EN
          frame_inc = 1'b1;
`endif
        end else begin
          gap_nxt = GAP;
          if (bus.full) begin
            state_nxt = DROP;
            err_nxt   = 1'b1;
            shift_nxt = 1'b0;
`ifdef XGMII_STATS_EN
            drop_inc  = 1'b1;
`endif
          end else if (shift) begin
            wr_en_nxt     = 1'b1;
            din_nxt       = merged;
            hold_ctrl_nxt = rx_ctrl[7:4];
            hold_data_nxt = rx_data[63:32];
          end else begin
            wr_en_nxt = 1'b1;
            din_nxt   = bus.xgmii_rxd;
          end
        end
      end
      DROP: begin
        if (is_idle) begin
          state_nxt = IDLE;
          if (err_pend && !bus.full) begin
            wr_en_nxt = 1'b1;
            din_nxt   = ERR_WORD;
            err_nxt   = 1'b0;
          end
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase

    // A pending error marker takes precedence over gap idles and the flush.
    if (do_idle) begin
      if (err_pend) begin
        if (!bus.full) begin
          wr_en_nxt = 1'b1;
          din_nxt   = ERR_WORD;
          err_nxt   = 1'b0;
        end
      end else if ((gap_cnt != 4'd0) && !bus.full) begin
        wr_en_nxt = 1'b1;
        if (shift) begin
          din_nxt   = flush;
          shift_nxt = 1'b0;
        end else begin
          din_nxt = IDLE_WORD;
          gap_nxt = gap_cnt - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= WAIT_IDLE;
      hold_ctrl <= '0;
      hold_data <= '0;
      shift     <= 1'b0;
      gap_cnt   <= '0;
      err_pend  <= 1'b0;
      din_q     <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_ctrl <= hold_ctrl_nxt;
      hold_data <= hold_data_nxt;
      shift     <= shift_nxt;
      gap_cnt   <= gap_nxt;
      err_pend  <= err_nxt;
      din_q     <= din_nxt;
      wr_en_q   <= wr_en_nxt;
    end
  end

`ifdef XGMII_STATS_EN
  always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_inc) frame_cnt <= frame_cnt + CNT_W'(1);
      if (drop_inc)  drop_cnt  <= drop_cnt + CNT_W'(1);
    end
  end
`endif

  assign bus.din    = din_q;
  assign bus.wr_en  = wr_en_q;
  assign bus.wr_clk = xgmii_rx_clk;

endmodule
`default_nettype wire

// File: tb/tb_xgmii_rx_fifo_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_xgmii_rx_fifo_writer : directed plus random frames against a lane-queue
// reference model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_xgmii_rx_fifo_writer;

  localparam logic [3:0]  GAP   = 4'h2;
  localparam bit          ALIGN = 1'b1;
  localparam logic [71:0] IDLEW = 72'hff_0707070707070707;
  localparam logic [71:0] ERRW  = 72'hff_07070707070707fe;
  localparam logic [71:0] TERMW = 72'hff_07070707070707fd;
  localparam int M_WAIT = 0, M_IDLE = 1, M_FRAME = 2, M_DROP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xgmii_rx_fifo_writer_if bus();
`ifdef XGMII_STATS_EN
  logic [31:0] frame_cnt, drop_cnt;
`endif

  xgmii_rx_fifo_writer #(.GAP(GAP), .ALIGN_LANE4(ALIGN), .CNT_W(32)) dut (
    .xgmii_rx_clk (clk),
    .sys_rst_n    (rst_n),
    .bus          (bus)
`ifdef XGMII_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: output is a stream of byte lanes {ctrl, data}.
  int         mode;
  logic [3:0] gap_m;
  bit         errp;
  logic [8:0] lq[$];
  int         frames_m, drops_m;

  // Per-segment observations.
  int          seg_writes, seg_err, seg_nonidle;
  logic [71:0] first_din;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mode = M_WAIT; gap_m = 4'd0; errp = 1'b0; lq.delete(); frames_m = 0; drops_m = 0;
  endtask

  task automatic push_lanes(input logic [71:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) lq.push_back({w[64+i], w[8*i +: 8]});
  endtask

  task automatic pop8(output logic [71:0] r);
    logic [8:0] e;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      e = lq.pop_front();
      r[64+i] = e[8];
      r[8*i +: 8] = e[7:0];
    end
  endtask

  task automatic idle_rule(input bit f, inout bit ew, inout logic [71:0] ed);
    if (errp) begin
      if (!f) begin ew = 1'b1; ed = ERRW; errp = 1'b0; end
    end else if (gap_m != 0 && !f) begin
      ew = 1'b1;
      if (lq.size() != 0) begin
        for (int i = 0; i < 4; i++) lq.push_back(9'h107);
        pop8(ed);
      end else begin
        ed = IDLEW; gap_m = gap_m - 4'd1;
      end
    end
  endtask

  task automatic model(input logic [71:0] w, input bit f, output bit ew, output logic [71:0] ed);
    bit idle, l4;
    idle = (w[71:64] == 8'hff) && (w[7:0] == 8'h07);
    l4   = ALIGN && w[68] && (w[39:32] == 8'hfb);
    ew = 1'b0; ed = '0;
    case (mode)
      M_WAIT: if (idle) mode = M_IDLE;
      M_IDLE: begin
        if (idle) idle_rule(f, ew, ed);
        else begin
          gap_m = GAP;
          if (f) begin mode = M_DROP; drops_m++; lq.delete(); end
          else if (l4) begin
            if (lq.size() != 0) begin push_lanes(w, 0, 3); ew = 1'b1; pop8(ed); end
            push_lanes(w, 4, 7); mode = M_FRAME;
          end else begin
            lq.delete(); ew = 1'b1; ed = w; mode = M_FRAME;
          end
        end
      end
      M_FRAME: begin
        if (idle) begin frames_m++; mode = M_IDLE; idle_rule(f, ew, ed); end
        else begin
          gap_m = GAP;
          if (f) begin mode = M_DROP; errp = 1'b1; drops_m++; lq.delete(); end
          else begin
            ew = 1'b1;
            if (lq.size() != 0) begin push_lanes(w, 0, 7); pop8(ed); end
            else ed = w;
          end
        end
      end
      default: if (idle) begin
        mode = M_IDLE;
        if (errp && !f) begin ew = 1'b1; ed = ERRW; errp = 1'b0; end
      end
    endcase
  endtask

  task automatic seg_clear();
    seg_writes = 0; seg_err = 0; seg_nonidle = 0; first_din = '0;
  endtask

  task automatic step(input logic [71:0] w, input bit f);
    bit ew;
    logic [71:0] ed;
    @(negedge clk);
    bus.xgmii_rxd = w;
    bus.full = f;
    model(w, f, ew, ed);
    @(posedge clk);
    #1;
    chk("wr_en", 72'(bus.wr_en), 72'(ew));
    if (ew) chk("din", bus.din, ed);
    if (bus.wr_en) begin
      if (seg_writes == 0) first_din = bus.din;
      seg_writes++;
      if (bus.din == ERRW) seg_err++;
      if (bus.din != IDLEW) seg_nonidle++;
    end
  endtask

  function automatic logic [71:0] sof0();
    return {8'h01, $urandom(), $urandom_range(0, 32'h00ffffff), 8'hfb} & 72'hff_ffffffffffffffff;
  endfunction
  function automatic logic [71:0] sof4();
    logic [23:0] hi = 24'($urandom());
    return {8'h1f, hi, 8'hfb, 32'h07070707};
  endfunction
  function automatic logic [71:0] dataw();
    return {8'h00, $urandom(), $urandom()};
  endfunction

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(IDLEW, 1'b0);
  endtask

  logic [71:0] w_sof, w_d1;

  initial begin
    bus.xgmii_rxd = '0;
    bus.full = 1'b0;
    model_reset();
    seg_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 72'(bus.wr_en), 72'h0);
    chk("rst_din", bus.din, 72'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame before any idle is discarded.
    seg_clear();
    step(sof0(), 1'b0);
    for (int i = 0; i < 3; i++) step(dataw(), 1'b0);
    step(TERMW, 1'b0);
    idles(4);
    chk("pre_idle_writes", 72'(seg_writes), 72'd0);

    // Lane-0 frame: 5 frame words + GAP idles.
    seg_clear();
    step({8'h01, 56'hd5555555555555, 8'hfb}, 1'b0);
    for (int i = 0; i < 3; i++) step(dataw(), 1'b0);
    step(TERMW, 1'b0);
    idles(5);
    chk("lane0_writes", 72'(seg_writes), 72'd7);
    chk("lane0_first", first_din, {8'h01, 56'hd5555555555555, 8'hfb});

    // Lane-4 SOF realigned to lane 0, flush on first idle.
    seg_clear();
    w_sof = sof4();
    w_d1 = dataw();
    step(w_sof, 1'b0);
    step(w_d1, 1'b0);
    for (int i = 0; i < 2; i++) step(dataw(), 1'b0);
    step(TERMW, 1'b0);
    idles(5);
    chk("lane4_fb", 72'(first_din[7:0]), 72'hfb);
    chk("lane4_first", first_din, {w_d1[67:64], w_sof[71:68], w_d1[31:0], w_sof[63:32]});
    chk("lane4_writes", 72'(seg_writes), 72'd7);

    // Full at SOF: frame dropped entirely.
    seg_clear();
    step(sof0(), 1'b1);
    for (int i = 0; i < 3; i++) step(dataw(), 1'b0);
    step(TERMW, 1'b0);
    idles(4);
    chk("drop_sof_nonidle", 72'(seg_nonidle), 72'd0);
    seg_clear();
    step(sof0(), 1'b0);
    for (int i = 0; i < 2; i++) step(dataw(), 1'b0);
    step(TERMW, 1'b0);
    idles(4);
    chk("after_drop_writes", 72'(seg_writes), 72'd6);

    // Full for two cycles mid-frame: truncation plus one error word.
    seg_clear();
    step(sof0(), 1'b0);
    step(dataw(), 1'b0);
    step(dataw(), 1'b1);
    step(dataw(), 1'b1);
    step(dataw(), 1'b0);
    step(TERMW, 1'b0);
    idles(5);
    chk("trunc_err_once", 72'(seg_err), 72'd1);

    // Randomised traffic.
    for (int fr = 0; fr < 60; fr++) begin
      int nidle = $urandom_range(1, 6);
      int nbody = $urandom_range(0, 5);
      for (int i = 0; i < nidle; i++) step(IDLEW, $urandom_range(0, 9) == 0);
      step(($urandom_range(0, 1) == 1) ? sof4() : sof0(), $urandom_range(0, 9) == 0);
      for (int i = 0; i < nbody; i++) step(dataw(), $urandom_range(0, 11) == 0);
      step(TERMW, $urandom_range(0, 11) == 0);
    end
    idles(6);
`ifdef XGMII_STATS_EN
    chk("frame_cnt", 72'(frame_cnt), 72'(frames_m));
    chk("drop_cnt", 72'(drop_cnt), 72'(drops_m));
`endif

    // Asynchronous reset in the middle of a frame.
    step(sof0(), 1'b0);
    step(dataw(), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 72'(bus.wr_en), 72'h0);
    chk("midrst_din", bus.din, 72'h0);
`ifdef XGMII_STATS_EN
    chk("midrst_frame_cnt", 72'(frame_cnt), 72'h0);
    chk("midrst_drop_cnt", 72'(drop_cnt), 72'h0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seg_clear();
    for (int i = 0; i < 3; i++) step(dataw(), 1'b0);
    step(TERMW, 1'b0);
    idles(3);
    chk("midrst_no_resume", 72'(seg_writes), 72'd0);
    step(sof0(), 1'b0);
    step(dataw(), 1'b0);
    step(TERMW, 1'b0);
    idles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
